// File: rtl/sram_pipe.sv
// sram_pipe: single-port line SRAM with a valid/ready request channel and an
// in-order, backpressured read-response channel.
//
// Reads sample the array at the acceptance edge, travel through a
// (DELAY-1)-stage valid-tagged pipeline and land in a RESP_DEPTH-entry
// response FIFO. A credit check (reads in flight + FIFO occupancy) guarantees
// that every accepted read has a FIFO slot, so the FIFO can never overflow.
// Writes are posted, honour per-word enables and produce no response.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset of control state (array kept)
//   req_valid_i   request present
//   req_ready_o   request accepted when req_valid_i && req_ready_o at an edge
//   req_write_i   1 = write, 0 = read
//   req_addr_i    line index
//   req_wdata_i   write line (only enabled words are used)
//   req_wen_i     per-word write enable, bit j covers [j*WW +: WW]
//   resp_valid_o  read data available at FIFO head
//   resp_ready_i  consumer pops the head when resp_valid_o && resp_ready_i
//   resp_data_o   read line at FIFO head

module sram_pipe #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned LOG_DEPTH = 9,
  parameter int unsigned LOG_WORDS = 3,
  parameter int unsigned DELAY     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [LOG_DEPTH-1:0]        req_addr_i,
  input  logic [WIDTH-1:0]            req_wdata_i,
  input  logic [(1<<LOG_WORDS)-1:0]   req_wen_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [WIDTH-1:0]            resp_data_o
);

  localparam int unsigned NWORDS     = 1 << LOG_WORDS;
  localparam int unsigned WW         = WIDTH >> LOG_WORDS;
  localparam int unsigned DEPTH      = 1 << LOG_DEPTH;
  localparam int unsigned RESP_DEPTH = DELAY + 1;
  localparam int unsigned PW         = $clog2(RESP_DEPTH);
  localparam int unsigned CW         = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SW         = CW + 1;

  if (DELAY < 1) begin : g_bad_delay
    $fatal(1, "sram_pipe: DELAY must be >= 1");
  end
  if ((WIDTH % NWORDS) != 0) begin : g_bad_width
    $fatal(1, "sram_pipe: WIDTH must be a multiple of 2^LOG_WORDS");
  end

  // Wrapping increment for the FIFO pointers (depth need not be a power of 2).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RESP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [WIDTH-1:0] mem_q  [DEPTH];
  logic [WIDTH-1:0] fifo_q [RESP_DEPTH];

  logic             accept_s;
  logic             rd_acc_s;
  logic             wr_acc_s;
  logic [WIDTH-1:0] rd_line_s;
  logic             push_vld_s;
  logic [WIDTH-1:0] push_data_s;
  logic             pop_s;
  logic [CW-1:0]    pend_s;
  logic [SW-1:0]    credit_s;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Ready is a pure function of state; resp_ready_i never feeds it.
  assign credit_s    = SW'(pend_s) + SW'(cnt_q);
  assign req_ready_o = (credit_s < SW'(RESP_DEPTH));
  assign accept_s    = req_valid_i && req_ready_o;
  assign rd_acc_s    = accept_s && !req_write_i;
  assign wr_acc_s    = accept_s && req_write_i;

  // The array read returns pre-edge contents, so a read never sees a write
  // accepted at the same edge but does see every earlier one.
  assign rd_line_s   = mem_q[req_addr_i];

  assign resp_valid_o = (cnt_q != '0);
  assign resp_data_o  = fifo_q[rd_ptr_q];
  assign pop_s        = resp_valid_o && resp_ready_i;

  // Array write with per-word enables; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NWORDS; j++) begin
      if (wr_acc_s && req_wen_i[j]) begin
        mem_q[req_addr_i][j*WW +: WW] <= req_wdata_i[j*WW +: WW];
      end
    end
  end

  if (DELAY > 1) begin : g_pipe
    logic [DELAY-2:0] vld_q, vld_d;
    logic [WIDTH-1:0] data_q [DELAY-1];

    // Next-state of the pipeline valid tags: shift in the read acceptance.
    always_comb begin
      vld_d    = vld_q;
      vld_d[0] = rd_acc_s;
      for (int i = 1; i < int'(DELAY) - 1; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end

    // Pipeline valid tags, cleared by reset so in-flight reads are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end

    // Pipeline data stages; only meaningful where the matching tag is set.
    always_ff @(posedge clk) begin
      data_q[0] <= rd_line_s;
      for (int i = 1; i < int'(DELAY) - 1; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    // Reads currently in flight in the pipeline.
    always_comb begin
      pend_s = '0;
      for (int i = 0; i < int'(DELAY) - 1; i++) begin
        pend_s = pend_s + CW'(vld_q[i]);
      end
    end

    assign push_vld_s  = vld_q[DELAY-2];
    assign push_data_s = data_q[DELAY-2];
  end else begin : g_nopipe
    // Single-cycle latency: the sampled line goes straight into the FIFO.
    assign pend_s      = '0;
    assign push_vld_s  = rd_acc_s;
    assign push_data_s = rd_line_s;
  end

  // Next-state of FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_vld_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_vld_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage write; data entries are not reset.
  always_ff @(posedge clk) begin
    if (push_vld_s) begin
      fifo_q[wr_ptr_q] <= push_data_s;
    end
  end

  sram_pipe_chk #(
    .CW         (CW),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_vld_s),
    .cnt_i  (cnt_q)
  );

endmodule

// sram_pipe_chk: protocol checks for sram_pipe.
// Ports: clk, rst_n, push_i (FIFO push this cycle), cnt_i (FIFO occupancy).
module sram_pipe_chk #(
  parameter int unsigned CW         = 2,
  parameter int unsigned RESP_DEPTH = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push_i,
  input logic [CW-1:0] cnt_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (cnt_i == CW'(RESP_DEPTH))))
    else $error("sram_pipe: push into full response FIFO");

endmodule
